// File: rtl/fifo_tx_serializer.sv
// rtl/fifo_tx_serializer.sv - FIFO drain to UART-style LSB-first serial frame
//
// Purpose: pops one word at a time from an upstream FIFO (RD/EMPTY/fifoData)
// and sends it as start bit, data_size data bits (LSB first), optional even
// parity bit, stop bit. Each serial bit lasts clks_per_bit Clk cycles.
//
// Optional feature: define FIFO_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Rst       in   synchronous active-low reset
//   EN        in   enables new word fetches; never aborts a frame in flight
//   EMPTY     in   FIFO empty flag, sampled only while idle
//   fifoData  in   FIFO read data, valid the cycle after RD
//   RD        out  one-cycle FIFO read strobe
//   TxD       out  registered serial line, idles high
//   Busy      out  high whenever not idle
//   Done      out  one-cycle pulse on the last cycle of the stop bit
module fifo_tx_serializer #(
  parameter int data_size    = 32,
  parameter int clks_per_bit = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 EN,
  input  logic                 EMPTY,
  input  logic [data_size-1:0] fifoData,
  output logic                 RD,
  output logic                 TxD,
  output logic                 Busy,
  output logic                 Done
);

  localparam int BW = $clog2(clks_per_bit);
  localparam int CW = $clog2(data_size + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(clks_per_bit - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(clks_per_bit - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(data_size - 1);

`ifdef FIFO_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [data_size-1:0] shift_reg;
  logic [CW-1:0]        bit_cnt;
  logic [BW-1:0]        baud_cnt;
  logic                 baud_last;
`ifdef FIFO_TX_PARITY_EN
  logic                 parity;
`endif

  assign baud_last = (baud_cnt == BAUD_LAST);

  // RD is a pure state decode so it can never appear outside REQ.
  assign RD = (state == REQ);

  // TxD, Busy and Done are updated together with the state so that their
  // registered values always describe the state being entered.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= IDLE;
      TxD       <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
`ifdef FIFO_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (EN && !EMPTY) begin
            state <= REQ;
            Busy  <= 1'b1;
          end
        end

        REQ: begin
          state <= LOAD;
        end

        // The FIFO registered its output on the REQ edge, so fifoData is
        // valid throughout this cycle.
        LOAD: begin
          shift_reg <= fifoData;
`ifdef FIFO_TX_PARITY_EN
          parity    <= ^fifoData;
`endif
          baud_cnt  <= '0;
          TxD       <= 1'b0;
          state     <= START;
        end

        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            TxD      <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        // The shift happens on the same edge as the TxD update, so the next
        // bit is taken from shift_reg[1] rather than the post-shift [0].
        DATA: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + CW'(1);
            if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_TX_PARITY_EN
              TxD   <= parity;
              state <= PARITY;
`else
              TxD   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              TxD <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

`ifdef FIFO_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            TxD      <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`endif

        // Done is raised one edge early so the registered pulse lands on
        // the final stop-bit cycle.
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            Busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
            if (baud_cnt == BAUD_PRE) begin
              Done <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          TxD      <= 1'b1;
          Busy     <= 1'b0;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule
